// File: rtl/data_sync_pkg.sv
// Shared definitions for the data synchronizer: state encodings, default width, counter sizing.
package data_sync_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_HOLD    = 3'd2,
        ST_GAP     = 3'd3,
        ST_REQ     = 3'd4,
        ST_RELEASE = 3'd5
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;

    function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
        int max_cycles;
        max_cycles = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit; resets to 0.
module bit_sync #(
    parameter int NUM_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [NUM_STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= (chain << 1) | NUM_STAGES'(d);
        end
    end

    assign q = chain[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_tx.sv
// Source-domain launcher: holds unsync_bus stable and toggles a registered bus_enable per word.
// Define DATA_SYNC_TX_ACK_EN for a closed-loop 4-phase handshake on dest_ack instead of fixed timing.
module data_sync_tx
    import data_sync_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int HOLD_CYCLES = 6,
    parameter int GAP_CYCLES  = 2,
    parameter int NUM_STAGES  = 2
) (
    input  logic                  src_clk,
    input  logic                  src_rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] unsync_bus,
    output logic                  bus_enable,
    output logic                  busy,
`ifdef DATA_SYNC_TX_ACK_EN
    input  logic                  dest_ack,
`endif
    output logic [2:0]            debug_state
);

    // Handshake: a word is taken on a rising edge where in_valid && in_ready; in_ready is high only in IDLE.
    localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES);

    // The receiver must see enable through its sync chain before it can drop.
    if (HOLD_CYCLES < NUM_STAGES + 2 || GAP_CYCLES < 1 || NUM_STAGES < 1) begin : g_bad_params
        $error("data_sync_tx: invalid HOLD_CYCLES/GAP_CYCLES/NUM_STAGES");
    end

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          accept;

`ifdef DATA_SYNC_TX_ACK_EN
    logic ack_s;
    logic armed;

    bit_sync #(.NUM_STAGES(NUM_STAGES)) u_ack_sync (
        .clk (src_clk),
        .rst (src_rst),
        .d   (dest_ack),
        .q   (ack_s)
    );

    // A stale-high ack must fall before its rising edge can complete the request.
    always_ff @(posedge src_clk or posedge src_rst) begin
        if (src_rst) begin
            armed <= 1'b0;
        end else if (state == ST_SETUP) begin
            armed <= ~ack_s;
        end else if (state == ST_REQ && !ack_s) begin
            armed <= 1'b1;
        end
    end
`endif

    always_ff @(posedge src_clk or posedge src_rst) begin
        if (src_rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            unsync_bus <= '0;
            bus_enable <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            bus_enable <= (state_next == ST_HOLD) || (state_next == ST_REQ);
            if (accept) begin
                unsync_bus <= in_data;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next = ST_SETUP;
                end
            end
`ifdef DATA_SYNC_TX_ACK_EN
            ST_SETUP: state_next = ST_REQ;
            ST_REQ: begin
                if (ack_s && armed) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!ack_s) begin
                    state_next = ST_IDLE;
                end
            end
`else
            ST_SETUP: begin
                state_next = ST_HOLD;
                cnt_next   = HOLD_LOAD;
            end
            ST_HOLD: begin
                if (cnt == CW'(1)) begin
                    state_next = ST_GAP;
                    cnt_next   = GAP_LOAD;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt == CW'(1)) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        in_ready    = (state == ST_IDLE);
        busy        = ~in_ready;
        accept      = in_ready && in_valid;
        debug_state = state;
    end

endmodule

// File: tb/tb_data_sync_tx.sv
// Bench for data_sync_tx: directed vector table, reset-in-HOLD sequence, random traffic vs timing model.
module tb_data_sync_tx;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int G  = 2;
    localparam int NS = 2;

    logic         src_clk = 1'b0;
    logic         src_rst = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] unsync_bus;
    logic         bus_enable;
    logic         busy;
    logic [2:0]   dbg_state;
`ifdef DATA_SYNC_TX_ACK_EN
    logic         dest_ack = 1'b0;
`endif

    data_sync_tx #(
        .DATA_WIDTH  (W),
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G),
        .NUM_STAGES  (NS)
    ) dut (
        .src_clk     (src_clk),
        .src_rst     (src_rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .unsync_bus  (unsync_bus),
        .bus_enable  (bus_enable),
        .busy        (busy),
`ifdef DATA_SYNC_TX_ACK_EN
        .dest_ack    (dest_ack),
`endif
        .debug_state (dbg_state)
    );

    always #5 src_clk = ~src_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic tick(input logic v, input logic [W-1:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge src_clk);
        @(negedge src_clk);
    endtask

    // Reference model: everything follows from the accept edge and the word taken there.
    int           edges  = 0;
    int           acc_at = -1;
    logic [W-1:0] m_bus  = '0;
    logic [W-1:0] exp_q[$];

    function automatic int phase();
        return (acc_at < 0) ? 1000 : edges - acc_at + 1;
    endfunction

    function automatic logic m_ready();
        return phase() >= H + G + 2;
    endfunction

    task automatic model_reset();
        acc_at = -1;
        m_bus  = '0;
        exp_q.delete();
    endtask

    task automatic mtick(input logic v, input logic [W-1:0] d);
        logic take;
        take = v && m_ready();
        tick(v, d);
        edges++;
        if (take) begin
            acc_at = edges;
            m_bus  = d;
            exp_q.push_back(d);
        end
    endtask

    task automatic model_check(input string tag);
        int   k;
        logic e_en;
        logic [W-1:0] w;
        k    = phase();
        e_en = (k >= 2) && (k <= H + 1);
        check({tag, "_bus"}, unsync_bus, m_bus);
        check({tag, "_en"}, bus_enable, e_en);
        check({tag, "_ready"}, in_ready, m_ready());
        check({tag, "_busy"}, busy, !m_ready());
        if (k == 2 && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check({tag, "_sb_word"}, unsync_bus, w);
        end
    endtask

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic [W-1:0] bus;
        logic         en;
        logic         rdy;
    } vec_t;

    vec_t vecs[21];

    initial begin
        vecs[0] = '{1'b1, 8'd5, 8'd5, 1'b0, 1'b0};
        for (int i = 1; i <= 6; i++) vecs[i] = '{1'b0, 8'd5, 8'd5, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'd5, 8'd5, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'd5, 8'd5, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'd5, 8'd5, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 8'd15, 8'd15, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 8'd15, 8'd15, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 8'd15, 8'd15, 1'b1, 1'b0};
        for (int i = 13; i <= 16; i++) vecs[i] = '{1'b0, 8'd20, 8'd15, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 8'd20, 8'd15, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 8'd20, 8'd15, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 8'd20, 8'd15, 1'b0, 1'b1};
        vecs[20] = '{1'b1, 8'd20, 8'd20, 1'b0, 1'b0};

        // Clock and reset
        #1 src_rst = 1'b1;
        #2;
        check("rst_bus", unsync_bus, 0);
        check("rst_en", bus_enable, 0);
        check("rst_ready", in_ready, 1);
        src_rst = 1'b0;
        @(negedge src_clk);

`ifndef DATA_SYNC_TX_ACK_EN
        for (int i = 0; i < 21; i++) begin
            tick(vecs[i].v, vecs[i].d);
            check($sformatf("vec%0d_bus", i), unsync_bus, vecs[i].bus);
            check($sformatf("vec%0d_en", i), bus_enable, vecs[i].en);
            check($sformatf("vec%0d_ready", i), in_ready, vecs[i].rdy);
        end

        // Reset while enable is high abandons the word at once.
        for (int i = 0; i < 3; i++) tick(1'b0, 8'd0);
        check("pre_rst_en", bus_enable, 1);
        src_rst = 1'b1;
        #1;
        check("midrst_bus", unsync_bus, 0);
        check("midrst_en", bus_enable, 0);
        check("midrst_ready", in_ready, 1);
        #1 src_rst = 1'b0;
        @(negedge src_clk);
        model_reset();
        model_check("post_rst");
        mtick(1'b1, 8'd7);
        model_check("w7");
        for (int i = 0; i < H + G + 2; i++) begin
            mtick(1'b0, 8'd0);
            model_check("w7");
        end

        for (int i = 0; i < 400; i++) begin
            mtick($urandom_range(0, 3) != 0, W'($urandom_range(0, 255)));
            model_check("rnd");
        end
`else
        begin
            int n;
            tick(1'b1, 8'h33);
            n = 0;
            while (!bus_enable && n < 20) begin tick(1'b0, 8'h00); n++; end
            check("ack_en_rise", bus_enable, 1);
            check("ack_bus", unsync_bus, 8'h33);
            for (int i = 0; i < 4; i++) tick(1'b0, 8'h00);
            dest_ack = 1'b1;
            n = 0;
            while (bus_enable && n < 20) begin tick(1'b0, 8'h00); n++; end
            check("ack_en_fall_lat", n, NS + 1);
            for (int i = 0; i < 4; i++) tick(1'b0, 8'h00);
            dest_ack = 1'b0;
            n = 0;
            while (!in_ready && n < 20) begin tick(1'b0, 8'h00); n++; end
            check("ack_ready_lat", n, NS + 1);

            tick(1'b1, 8'h44);
            for (int i = 0; i < 30; i++) tick(1'b0, 8'h00);
            check("ack_stuck_busy", busy, 1);
            check("ack_stuck_en", bus_enable, 1);
            src_rst = 1'b1;
            #1;
            check("ack_rst_en", bus_enable, 0);
            check("ack_rst_ready", in_ready, 1);
            #1 src_rst = 1'b0;
            @(negedge src_clk);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
